// File: rtl/reg_file_wb_arbiter.sv
// rtl/reg_file_wb_arbiter.sv - round-robin arbiter for the register file write port
// Optional x0/pending scoreboard enabled by WB_SCOREBOARD_EN.
module reg_file_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
`ifdef WB_SCOREBOARD_EN
  input  logic                         alloc_valid,
  input  logic [ADDR_W-1:0]            alloc_rd,
  output logic [(2**ADDR_W)-1:0]       pending,
`endif
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         w_en,
  output logic [ADDR_W-1:0]            rd,
  output logic [DATA_W-1:0]            rdv,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   next_ptr;
  logic              found;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  int                best_dist;
  int                cur_dist;
  int                win_idx;

  // Winner is the valid requester at the smallest circular distance from rr_ptr.
  always_comb begin
    found     = 1'b0;
    best_dist = NUM_REQ;
    cur_dist  = 0;
    win_idx   = 0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_dist = i - int'(rr_ptr);
      if (cur_dist < 0) cur_dist = cur_dist + NUM_REQ;
      if (rst_n && !hold && req_valid[i] && (cur_dist < best_dist)) begin
        found     = 1'b1;
        best_dist = cur_dist;
        win_idx   = i;
        sel_rd    = req_rd[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = found && (win_idx == i);
    end
  end

  assign gnt_idx  = ID_W'(win_idx);
  assign next_ptr = (win_idx == NUM_REQ - 1) ? '0 : ID_W'(win_idx + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en     <= 1'b0;
      rd       <= '0;
      rdv      <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      w_en <= 1'b0;
      if (found) begin
        rd       <= sel_rd;
        rdv      <= sel_data;
        grant_id <= gnt_idx;
        rr_ptr   <= next_ptr;
        if (sel_rd != '0) begin
          w_en <= 1'b1;
        end else if (drop_cnt != {CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [(2**ADDR_W)-1:0] pending_nxt;

  // Allocation is applied after the clear so a same-cycle re-allocation survives.
  always_comb begin
    pending_nxt = pending;
    if (w_en) pending_nxt[rd] = 1'b0;
    if (alloc_valid) pending_nxt[alloc_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end
`else
  // Default build carries no pending-register tracking.
`endif

endmodule

// File: doc/reg_file_wb_arbiter.md
Name: reg_file_wb_arbiter

Overview:
Shares the register file's single write port (w_en/rd/rdv) between NUM_REQ write-back requesters, such as the ALU, load unit and CSR unit. It arbitrates round-robin, uses a valid/ready handshake per requester and drives registered write-port signals one cycle after grant. Writes to x0 are accepted and discarded, and each discard is counted. The block sits between the execute/memory stages and reg_file.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width
CNT_W, 16, width of the x0-drop counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
hold  input  1  when 1, no grants this cycle
req_valid  input  NUM_REQ  per-requester write request
req_rd  input  NUM_REQ*ADDR_W  packed dest addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant (combinational)
w_en  output  1  register file write enable (registered)
rd  output  ADDR_W  register file dest address (registered)
rdv  output  DATA_W  register file write data (registered)
grant_id  output  $clog2(NUM_REQ)  index of last granted requester (registered)
drop_cnt  output  CNT_W  count of x0 writes discarded (saturating)

Behaviour:
- Reset (async assert, rst_n=0): w_en=0, rd=0, rdv=0, grant_id=0, drop_cnt=0, rr_ptr=0, req_ready=0.
- Arbitration (combinational): with hold=0, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Grant signalling: req_ready[i]=1 only for the granted index; at most one bit set. With hold=1 or no valid, req_ready=0.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid/rd/data stable until ready. The block never asserts ready without valid.
- Commit (next edge after a transfer): rd<=req_rd[i], rdv<=req_data[i], grant_id<=i, rr_ptr<=(i+1) mod NUM_REQ.
  - If req_rd[i]!=0: w_en<=1.
  - If req_rd[i]==0: w_en<=0, drop_cnt<=drop_cnt+1, saturating at all-ones.
- Latency: write-port signals are valid exactly 1 cycle after the handshake. Back-to-back grants give w_en=1 on consecutive cycles.
- No transfer in a cycle: w_en<=0; rd, rdv, grant_id and rr_ptr hold.
- Fairness: any continuously valid requester is granted within NUM_REQ cycles while hold=0.
- hold=1 mid-stream: the commit already registered still appears on the next cycle. No new grant is made; rr_ptr holds.
- Reset mid-operation: a write registered but not yet consumed is lost. w_en drops immediately with rst_n. After release, the first grant scans from index 0.

Optional Feature:
WB_SCOREBOARD_EN
- With macro defined: adds inputs alloc_valid(1) and alloc_rd(ADDR_W), and output pending(2**ADDR_W).
  - alloc_valid sets pending[alloc_rd].
  - A committing write with w_en=1 clears pending[rd] on the edge after w_en is seen.
  - Simultaneous set and clear of the same bit: set wins.
  - pending[0] is always 0.
  - Reset clears all bits.
- Without macro: these ports and the pending state are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then requester 0 valid with rd=5, data=0xABCD1234 → req_ready=001 that cycle; next cycle w_en=1, rd=5, rdv=0xABCD1234, grant_id=0.
2. All three valid continuously (rd=1,2,3) → grants in order 0,1,2,0; w_en=1 on 4 consecutive cycles with rd sequence 1,2,3,1.
3. Requester 1 valid with rd=0, data=0xFFFFFFFF → ready asserted; next cycle w_en=0, drop_cnt 0→1; a later read of reg[0] in reg_file returns 0x00000000.
4. hold=1 for 3 cycles while requester 2 is valid (rd=10, data=0x12345678) → req_ready=000 and w_en=0 throughout; after hold=0, grant on the first cycle, then w_en=1, rd=10.
5. rst_n pulsed low while w_en=1 → w_en=0 and drop_cnt=0 immediately; after release with req 1 and req 2 valid, first grant goes to 1.
6. (WB_SCOREBOARD_EN) alloc rd=7 → pending[7]=1; requester 0 writes rd=7 → pending[7] clears one cycle after w_en; alloc rd=7 in the same cycle as the clear → pending[7] stays 1.
